wb_master_bridge: RTL and testbench

- Wishbone B4 pipelined initiator. Converts single-beat requests from an internal agent (debug/DMA/boot loader) into Wishbone cycles toward the peripheral-bus Wishbone slave and the other slaves.
- One outstanding transaction. Registered outputs. Per-cycle timeout so a dead slave cannot hang the agent.
- Sits on the initiator side of the same Wishbone fabric that feeds the peripheral block.

---
 rtl/wb_pkg.sv | 11 +
 rtl/wb_master_bridge.sv | 90 +++++++++
 tb/tb_wb_master_bridge.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone widths and bridge state encoding
package wb_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int SEL_WIDTH = 4;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQUEST  = 2'd1,
    WAIT_ACK = 2'd2,
    RESPOND  = 2'd3
  } state_t;
endpackage

// File: rtl/wb_master_bridge.sv
// wb_master_bridge: single-outstanding Wishbone B4 pipelined initiator with per-cycle timeout
module wb_master_bridge
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int COUNTER_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [SEL_WIDTH-1:0]  req_sel,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [SEL_WIDTH-1:0]  wb_sel_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_stall_i,
  input  logic                  wb_error_i
);
  localparam logic [COUNTER_WIDTH-1:0] TMO_LAST =
    COUNTER_WIDTH'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
  localparam logic TMO_EN = TIMEOUT_CYCLES != 0;
  state_t state, state_d;
  logic [COUNTER_WIDTH-1:0] cnt;
  logic busy, done, tmo;
  // next state; a stalled REQUEST cycle cannot complete, and a real completion beats the timeout
  always_comb begin
    busy = state == REQUEST || state == WAIT_ACK;
    done = (state == WAIT_ACK || (state == REQUEST && !wb_stall_i)) && (wb_ack_i || wb_error_i);
    tmo = TMO_EN && busy && !done && cnt == TMO_LAST;
    state_d = state;
    unique case (state)
      IDLE:     state_d = req_valid ? REQUEST : IDLE;
      REQUEST:  state_d = (done || tmo) ? RESPOND : wb_stall_i ? REQUEST : WAIT_ACK;
      WAIT_ACK: state_d = (done || tmo) ? RESPOND : WAIT_ACK;
      default:  state_d = IDLE;
    endcase
  end
  // state, registered bus/handshake outputs, timeout counter and response capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_sel_o    <= '0;
      wb_adr_o    <= '0;
      wb_data_o   <= '0;
      cnt         <= '0;
    end else begin
      state     <= state_d;
      req_ready <= state_d == IDLE;
      wb_cyc_o  <= state_d == REQUEST || state_d == WAIT_ACK;
      wb_stb_o  <= state_d == REQUEST;
      rsp_valid <= state_d == RESPOND;
      if (state == IDLE && req_valid) begin
        wb_we_o   <= req_we;
        wb_sel_o  <= req_sel;
        wb_adr_o  <= req_addr;
        wb_data_o <= req_data;
        cnt       <= '0;
      end else if (busy && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (busy && state_d == RESPOND) begin
        rsp_error   <= tmo || wb_error_i;
        rsp_timeout <= tmo;
        rsp_data    <= (done && !wb_error_i && !wb_we_o) ? wb_data_i : '0;
      end
    end
  end
endmodule

// File: tb/tb_wb_master_bridge.sv
// tb_wb_master_bridge: directed self-checking bench for wb_master_bridge
module tb_wb_master_bridge;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [3:0] req_sel = '0;
  logic [23:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic rsp_valid, rsp_error, rsp_timeout;
  logic [31:0] rsp_data;
  logic wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0] wb_sel_o;
  logic [23:0] wb_adr_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i = '0;
  logic wb_ack_i = 1'b0, wb_stall_i = 1'b0, wb_error_i = 1'b0;
  int errors = 0;
  int checks = 0;

  wb_master_bridge #(.ADDR_WIDTH(24), .TIMEOUT_CYCLES(8), .COUNTER_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_sel(req_sel),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_adr_o(wb_adr_o), .wb_data_o(wb_data_o), .wb_data_i(wb_data_i),
    .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i), .wb_error_i(wb_error_i)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic we, input logic [3:0] sel, input logic [23:0] addr, input logic [31:0] data);
    req_valid = 1'b1;
    req_we = we;
    req_sel = sel;
    req_addr = addr;
    req_data = data;
    tick;
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++; if ({wb_cyc_o, wb_stb_o, rsp_valid, rsp_error, rsp_timeout} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {wb_cyc_o, wb_stb_o, rsp_valid, rsp_error, rsp_timeout}); end
    checks++; if ({wb_adr_o, wb_data_o, rsp_data} !== '0) begin errors++; $display("FAIL reset_data got %h/%h/%h exp 0", wb_adr_o, wb_data_o, rsp_data); end
    @(posedge clk);
    #1 rst = 1'b1;
    tick;
  endtask

  task automatic test_read;
    start_req(1'b0, 4'hF, 24'h000010, 32'h0);
    checks++; if ({wb_cyc_o, wb_stb_o, req_ready} !== 3'b110) begin errors++; $display("FAIL read_stb got %b exp 110", {wb_cyc_o, wb_stb_o, req_ready}); end
    checks++; if (wb_adr_o !== 24'h000010) begin errors++; $display("FAIL read_adr got %h exp 000010", wb_adr_o); end
    tick;
    checks++; if ({wb_cyc_o, wb_stb_o} !== 2'b10) begin errors++; $display("FAIL read_wait got %b exp 10", {wb_cyc_o, wb_stb_o}); end
    wb_ack_i = 1'b1;
    wb_data_i = 32'hDEADBEEF;
    tick;
    wb_ack_i = 1'b0;
    wb_data_i = 32'h0;
    checks++; if ({rsp_valid, rsp_error, rsp_timeout, wb_cyc_o} !== 4'b1000) begin errors++; $display("FAIL read_rsp_flags got %b exp 1000", {rsp_valid, rsp_error, rsp_timeout, wb_cyc_o}); end
    checks++; if (rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rsp_data got %h exp deadbeef", rsp_data); end
    tick;
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL read_after got %b exp 01", {rsp_valid, req_ready}); end
    checks++; if (rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL read_hold got %h exp deadbeef", rsp_data); end
  endtask

  task automatic test_write_stall;
    wb_stall_i = 1'b1;
    wb_data_i = 32'hFFFF0000;
    start_req(1'b1, 4'b0011, 24'h000020, 32'h12345678);
    for (int i = 0; i < 4; i++) begin
      checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_data_o} !== {3'b111, 4'b0011, 24'h000020, 32'h12345678}) begin errors++; $display("FAIL write_stall%0d got %b%b%b %b %h %h", i, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_data_o); end
      wb_ack_i = (i == 1);
      wb_stall_i = (i != 3);
      tick;
    end
    wb_ack_i = 1'b0;
    checks++; if ({wb_cyc_o, wb_stb_o, rsp_valid} !== 3'b100) begin errors++; $display("FAIL write_wait got %b exp 100", {wb_cyc_o, wb_stb_o, rsp_valid}); end
    tick;
    checks++; if ({wb_cyc_o, rsp_valid, wb_adr_o, wb_data_o} !== {2'b10, 24'h000020, 32'h12345678}) begin errors++; $display("FAIL write_wait2 got %b%b %h %h", wb_cyc_o, rsp_valid, wb_adr_o, wb_data_o); end
    wb_ack_i = 1'b1;
    tick;
    wb_ack_i = 1'b0;
    checks++; if ({rsp_valid, rsp_error, wb_cyc_o, rsp_data} !== {3'b100, 32'h0}) begin errors++; $display("FAIL write_rsp got %b%b%b %h exp 100 0", rsp_valid, rsp_error, wb_cyc_o, rsp_data); end
    tick;
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL write_single got %b exp 01", {rsp_valid, req_ready}); end
    wb_data_i = 32'h0;
  endtask

  task automatic test_error;
    wb_data_i = 32'hAAAA5555;
    start_req(1'b0, 4'hF, 24'h000030, 32'h0);
    wb_error_i = 1'b1;
    tick;
    wb_error_i = 1'b0;
    checks++; if ({rsp_valid, rsp_error, rsp_timeout, rsp_data} !== {3'b110, 32'h0}) begin errors++; $display("FAIL err_rsp got %b%b%b %h exp 110 0", rsp_valid, rsp_error, rsp_timeout, rsp_data); end
    tick;
    start_req(1'b0, 4'hF, 24'h000034, 32'h0);
    tick;
    wb_ack_i = 1'b1;
    wb_error_i = 1'b1;
    tick;
    wb_ack_i = 1'b0;
    wb_error_i = 1'b0;
    checks++; if ({rsp_valid, rsp_error, rsp_timeout, rsp_data} !== {3'b110, 32'h0}) begin errors++; $display("FAIL ackerr_rsp got %b%b%b %h exp 110 0", rsp_valid, rsp_error, rsp_timeout, rsp_data); end
    tick;
    wb_data_i = 32'h0;
  endtask

  task automatic test_timeout;
    int n = 0;
    int extra = 0;
    start_req(1'b0, 4'hF, 24'h000040, 32'h0);
    while (wb_cyc_o && n < 20) begin
      n++;
      tick;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL tmo_cycles got %0d exp 8", n); end
    checks++; if ({rsp_valid, rsp_error, rsp_timeout, wb_stb_o, rsp_data} !== {4'b1110, 32'h0}) begin errors++; $display("FAIL tmo_rsp got %b%b%b%b %h exp 1110 0", rsp_valid, rsp_error, rsp_timeout, wb_stb_o, rsp_data); end
    for (int i = 0; i < 6; i++) begin
      wb_ack_i = (i == 2);
      tick;
      if (rsp_valid) extra++;
    end
    wb_ack_i = 1'b0;
    checks++; if (extra !== 0) begin errors++; $display("FAIL tmo_late_ack got %0d exp 0", extra); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL tmo_idle got %b exp 1", req_ready); end
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    start_req(1'b0, 4'hF, 24'h000050, 32'h0);
    tick;
    checks++; if ({wb_cyc_o, wb_stb_o} !== 2'b10) begin errors++; $display("FAIL rst_wait got %b exp 10", {wb_cyc_o, wb_stb_o}); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({wb_cyc_o, wb_stb_o, req_ready} !== 3'b001) begin errors++; $display("FAIL rst_async got %b exp 001", {wb_cyc_o, wb_stb_o, req_ready}); end
    tick;
    rst = 1'b1;
    wb_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (rsp_valid) seen++;
    end
    wb_ack_i = 1'b0;
    checks++; if ({seen[3:0], req_ready} !== 5'b00001) begin errors++; $display("FAIL rst_norsp got rsp=%0d ready=%b exp 0 1", seen, req_ready); end
    start_req(1'b0, 4'hF, 24'h000054, 32'h0);
    wb_ack_i = 1'b1;
    wb_data_i = 32'h0BADF00D;
    tick;
    wb_ack_i = 1'b0;
    checks++; if ({rsp_valid, rsp_error, rsp_data} !== {2'b10, 32'h0BADF00D}) begin errors++; $display("FAIL rst_read got %b%b %h exp 10 0badf00d", rsp_valid, rsp_error, rsp_data); end
    tick;
    wb_data_i = 32'h0;
  endtask

  task automatic test_back_to_back;
    logic [23:0] addrs [3] = '{24'h000100, 24'h000204, 24'h000308};
    int nacc = 0;
    int nrsp = 0;
    int last = 0;
    for (int i = 0; i < 18; i++) begin
      checks++; if (req_ready !== !(wb_cyc_o || rsp_valid)) begin errors++; $display("FAIL b2b_ready%0d got %b exp %b", i, req_ready, !(wb_cyc_o || rsp_valid)); end
      if (rsp_valid) begin
        checks++; if (nrsp > 2 || rsp_data !== {8'hB0, addrs[nrsp > 2 ? 2 : nrsp]}) begin errors++; $display("FAIL b2b_data%0d got %h", nrsp, rsp_data); end
        if (nrsp > 0) begin
          checks++; if (i - last !== 4) begin errors++; $display("FAIL b2b_spacing got %0d exp 4", i - last); end
        end
        last = i;
        nrsp++;
      end
      if (req_ready) begin
        if (nacc < 3) begin
          req_valid = 1'b1;
          req_we = 1'b0;
          req_addr = addrs[nacc];
          nacc++;
        end else req_valid = 1'b0;
      end
      wb_ack_i = wb_cyc_o && !wb_stb_o;
      wb_data_i = {8'hB0, wb_adr_o};
      tick;
    end
    req_valid = 1'b0;
    wb_ack_i = 1'b0;
    checks++; if (nrsp !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", nrsp); end
  endtask

  initial begin
    test_reset;
    test_read;
    test_write_stall;
    test_error;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
